// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the dmem_resp data-memory responder.
package dmem_resp_pkg;

  localparam int WAIT_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

endpackage

// File: rtl/dmem_resp_align.sv
// Lane steering for dmem_resp: byte enables, store-data replication,
// load extraction with sign/zero extension, and the alignment check.
module dmem_resp_align
  import dmem_resp_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Anything that is not byte or half is steered as a full word.
  always_comb begin
    byte_en     = 4'b1111;
    wdata_lanes = wdata;
    rdata       = rword;
    misaligned  = (addr_lo != 2'b00);
    case (size)
      SZ_BYTE: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata       = is_unsigned ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
        misaligned  = 1'b0;
      end
      SZ_HALF: begin
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata       = is_unsigned ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
        misaligned  = addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder with programmable wait states between request and array access.
// Define DMEM_RESP_ERR_EN to enable misalignment, illegal-size and range faults.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [31:0] Req_Addr,
  input  logic [1:0]  Req_Size,
  input  logic        Req_Unsigned,
  input  logic [31:0] Req_WData,
  output logic        Rsp_Valid,
  input  logic        Rsp_Ready,
  output logic [31:0] Rsp_RData,
  output logic        Rsp_Err,
  output logic        Busy
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_30 = 30'(DEPTH_WORDS);

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  logic              write_q, unsigned_q;
  logic [31:0]       addr_q, wdata_q;
  logic [1:0]        size_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept, to_resp;
  logic              acc_write, acc_unsigned, acc_err;
  logic [31:0]       acc_addr, acc_wdata;
  logic [1:0]        acc_size, eff_size, eff_lo;
  logic [IDX_W-1:0]  word_idx;
  logic              misaligned;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_lanes, load_data;

  assign Req_Ready = (state == IDLE);
  assign Busy      = ~Req_Ready;
  assign Rsp_Valid = (state == RESP);
  assign accept    = Req_Valid & Req_Ready;
  assign to_resp   = (accept && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (cnt == WAIT_W'(1)));

  // With zero wait states the array is accessed on the acceptance edge, before the latches load.
  assign acc_write    = (state == IDLE) ? Req_Write    : write_q;
  assign acc_addr     = (state == IDLE) ? Req_Addr     : addr_q;
  assign acc_size     = (state == IDLE) ? Req_Size     : size_q;
  assign acc_unsigned = (state == IDLE) ? Req_Unsigned : unsigned_q;
  assign acc_wdata    = (state == IDLE) ? Req_WData    : wdata_q;

`ifdef DMEM_RESP_ERR_EN
  assign eff_size = acc_size;
  assign eff_lo   = acc_addr[1:0];
  assign word_idx = acc_addr[IDX_W+1:2];
  assign acc_err  = (acc_size == SZ_ILL) || misaligned || (acc_addr[31:2] >= DEPTH_30);
`else
  logic unused_misaligned;
  assign eff_size = (acc_size == SZ_ILL) ? SZ_WORD : acc_size;
  assign eff_lo   = (eff_size == SZ_WORD) ? 2'b00 :
                    (eff_size == SZ_HALF) ? {acc_addr[1], 1'b0} : acc_addr[1:0];
  assign word_idx = IDX_W'(acc_addr[31:2] % DEPTH_30);
  assign acc_err  = 1'b0;
  assign unused_misaligned = misaligned;
`endif

  dmem_resp_align u_align (
    .addr_lo     (eff_lo),
    .size        (eff_size),
    .is_unsigned (acc_unsigned),
    .wdata       (acc_wdata),
    .rword       (mem[word_idx]),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata       (load_data),
    .misaligned  (misaligned)
  );

  // Array contents survive reset; a store commits only on the edge into RESP.
  always_ff @(posedge clk) begin
    if (to_resp && acc_write && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      cnt        <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      Rsp_RData  <= '0;
      Rsp_Err    <= 1'b0;
    end else begin
      if (to_resp) begin
        Rsp_Err   <= acc_err;
        Rsp_RData <= (acc_write || acc_err) ? '0 : load_data;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            write_q    <= Req_Write;
            addr_q     <= Req_Addr;
            size_q     <= Req_Size;
            unsigned_q <= Req_Unsigned;
            wdata_q    <= Req_WData;
            cnt        <= WAIT_W'(WAIT_CYCLES);
            state      <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - WAIT_W'(1);
          if (cnt == WAIT_W'(1)) state <= RESP;
        end
        RESP: begin
          if (Rsp_Ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
